sram_stream_writer: RTL
=======================

# sram_stream_writer

Upstream producer for the SRAM write port (wrData/wrAddr/wrEn bundle). Accepts a valid/ready byte stream, e.g. work data arriving from the host link, and writes a commanded number of words into consecutive SRAM addresses starting at a programmable base. Signals completion with a one-cycle done pulse so the downstream consumer (hashing core) can start on the buffered block.

## Interface
Parameters:
- ADDR_WIDTH, 10, SRAM address width; also sets address wrap modulus 2^ADDR_WIDTH
- DATA_WIDTH, 8, SRAM word and stream beat width

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle transfer request, sampled only in IDLE
- baseAddr  in  ADDR_WIDTH  first write address, captured on start
- len  in  ADDR_WIDTH+1  number of words to write (0..2^ADDR_WIDTH), captured on start
- abort  in  1  terminate current transfer, no done pulse
- inData  in  DATA_WIDTH  stream payload
- inValid  in  1  stream beat valid
- inReady  out  1  stream beat accepted when inValid && inReady
- wrData  out  DATA_WIDTH  SRAM write data (master side of write bundle)
- wrAddr  out  ADDR_WIDTH  SRAM write address
- wrEn  out  1  SRAM write strobe, one word per asserted cycle
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, transfer completed normally
- count  out  ADDR_WIDTH+1  words written in current/last transfer

## Operation
- States: IDLE, WRITE.
- IDLE: inReady=0. On start: capture baseAddr into address pointer, len into remaining counter, clear count. If len!=0 -> WRITE; if len==0 -> stay IDLE, pulse done next cycle, no writes.
- start while in WRITE is ignored (no re-capture).
- WRITE: inReady=1 combinationally from state (does not depend on inValid). Each accepted beat: register wrData<=inData, wrAddr<=pointer, wrEn<=1; pointer<=pointer+1 modulo 2^ADDR_WIDTH; remaining<=remaining-1; count<=count+1.
- Accepting the beat with remaining==1 -> IDLE next cycle; done=1 in that same next cycle, coincident with the final wrEn.
- abort in WRITE -> IDLE next cycle; a beat accepted in the abort cycle is still written (abort takes effect after it); no done; count holds words written. abort in IDLE has no effect. abort and start same cycle in IDLE: start wins (abort ignored in IDLE).
- Address wrap: pointer rolls from 2^ADDR_WIDTH-1 to 0 silently; len=2^ADDR_WIDTH writes every location exactly once.
- No accepted beat in a cycle -> wrEn=0 next cycle; wrData/wrAddr hold last values.

## Timing
- Reset values: inReady=0, wrEn=0, wrData=0, wrAddr=0, busy=0, done=0, count=0; state IDLE; pointer/remaining 0.
- Reset mid-transfer: immediate return to reset values; partially written words are not reported.
- start sampled at edge N -> busy=1, inReady=1 from cycle N+1.
- Beat accepted at edge K -> wrEn/wrAddr/wrData valid during cycle K+1 (latency 1, registered outputs).
- Throughput: one word per cycle with inValid held high; len words take len cycles after first acceptance, plus 1 cycle for final write.
- Last beat accepted at edge K -> cycle K+1: wrEn=1, done=1, busy=0, inReady=0. New start accepted at edge K+1.
- busy = (state==WRITE), registered state, no combinational path from inputs.

## Test plan
- Basic: baseAddr=0x010, len=4, stream 0xA0..0xA3 with continuous valid -> wrEn 4 consecutive cycles at 0x010..0x013 with data A0..A3; done on cycle of 4th write; count=4.
- Backpressure-free gaps: len=3, inValid toggles 1,0,1,0,1 -> exactly 3 writes, wrEn low in gap cycles, addresses contiguous, done with 3rd write.
- Wrap: baseAddr=0x3FE, len=4 -> writes at 0x3FE,0x3FF,0x000,0x001; done asserted; count=4.
- len=0 and len=1024: len=0 -> done one cycle after start, wrEn never set; len=1024 -> every address 0..0x3FF written once, count=1024.
- Abort: len=8, abort after 3 accepted beats (abort cycle accepts 4th) -> 4 writes, no done, busy drops, count=4; start during WRITE ignored.
- Async reset mid-transfer: assert Rst after 2 writes of len=5 -> all outputs immediately to reset values; subsequent start with len=2 completes normally.

Source files
------------

// File: rtl/sram_stream_writer.sv
// rtl/sram_stream_writer.sv - stream-to-SRAM block writer
// Writes len stream beats to consecutive SRAM addresses from baseAddr, pulses done at the end.
module sram_stream_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] wrData,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic                  wrEn,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    count_d   = count_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = baseAddr;
          rem_d   = len;
          count_d = '0;
          // A zero-length request completes without ever opening the stream.
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (inValid) begin
          wr_data_d = inData;
          wr_addr_d = ptr_q;
          wr_en_d   = 1'b1;
          ptr_d     = ptr_q + PTR_ONE;
          rem_d     = rem_q - CNT_ONE;
          count_d   = count_q + CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = !abort;
          end
        end
        // The beat taken in the abort cycle is still written above.
        if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
    end
  end

  assign inReady = (state_q == WRITE);
  assign busy    = (state_q == WRITE);
  assign wrData  = wr_data_q;
  assign wrAddr  = wr_addr_q;
  assign wrEn    = wr_en_q;
  assign done    = done_q;
  assign count   = count_q;

endmodule
